maxpool_stream: RTL

Parametrised 2×2 / stride-2 max-pooling engine for the CNN feature-map pipeline. It sits between a mid-layer row-pair buffer (e.g. the conv1 output buffers) and the next layer's banked input BRAMs. Compared with the fixed 3-channel pooler, channel count, data width, frame size and output bank count are parameters. Comparison is signed, and output rows are striped round-robin across NBANK banks.

---
 rtl/maxpool_stream.sv | 118 +++++++++++
 1 files changed

// File: rtl/maxpool_stream.sv
// maxpool_stream: 2x2 stride-2 signed max-pooling of a row-pair source into NBANK striped banks.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_stream #(
  parameter int BD = 18,
  parameter int CH = 3,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int AW = 11,
  parameter int NBANK = 4,
  localparam int BW = NBANK > 1 ? $clog2(NBANK) : 1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             ready_in,
  input  logic [CH*BD-1:0] q0,
  input  logic [CH*BD-1:0] q1,
  output logic             mpen,
  output logic [AW-1:0]    rdaddr,
  output logic             wren,
  output logic [AW-1:0]    wraddr,
  output logic [CH*BD-1:0] d,
  output logic [BW-1:0]    bram_num,
  output logic             busy,
  output logic             next_st
);
  localparam int LAST_C = IMG_W - 1;
  localparam int LAST_R = IMG_H / 2 - 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;
  logic [AW-1:0] r, c, wa_c, s1_wa;
  logic [BW-1:0] bk_c, s1_bk;
  logic dr, s1_vld, s1_odd;
  logic [CH*BD-1:0] v, mx, pl;
  logic last_c;
  assign last_c = c == AW'(LAST_C);
  assign wa_c = AW'((r >> $clog2(NBANK)) * AW'(IMG_W / 2)) + (c >> 1);
  assign bk_c = BW'(r & AW'(NBANK - 1));
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      mpen <= 1'b0;
      rdaddr <= '0;
      r <= '0;
      c <= '0;
      dr <= 1'b0;
      busy <= 1'b0;
      next_st <= 1'b0;
    end else begin
      next_st <= 1'b0;
      case (state)
        IDLE: if (ready_in) begin
          state <= READ;
          mpen <= 1'b1;
          busy <= 1'b1;
          rdaddr <= '0;
          r <= '0;
          c <= '0;
        end
        READ: begin
          rdaddr <= rdaddr + 1'b1;
          c <= last_c ? '0 : c + 1'b1;
          r <= last_c ? r + 1'b1 : r;
          if (last_c && r == AW'(LAST_R)) begin
            state <= DRAIN;
            mpen <= 1'b0;
            dr <= 1'b0;
          end
        end
        DRAIN: begin
          dr <= 1'b1;
          if (dr) begin
            state <= DONE;
            next_st <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  // Even column max is held in v; the odd column's vertical max is folded in combinationally.
  always_comb begin
    mx = '0;
    pl = '0;
    for (int k = 0; k < CH; k++) begin
      mx[k*BD +: BD] = ($signed(q1[k*BD +: BD]) > $signed(q0[k*BD +: BD])) ? q1[k*BD +: BD] : q0[k*BD +: BD];
      pl[k*BD +: BD] = ($signed(mx[k*BD +: BD]) > $signed(v[k*BD +: BD])) ? mx[k*BD +: BD] : v[k*BD +: BD];
`ifdef MAXPOOL_RELU_EN
      if (pl[k*BD + BD - 1]) pl[k*BD +: BD] = '0;
`endif
    end
  end
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) begin
      s1_vld <= 1'b0;
      s1_odd <= 1'b0;
      s1_wa <= '0;
      s1_bk <= '0;
      v <= '0;
      wren <= 1'b0;
      wraddr <= '0;
      bram_num <= '0;
      d <= '0;
    end else begin
      s1_vld <= mpen;
      s1_odd <= c[0];
      s1_wa <= wa_c;
      s1_bk <= bk_c;
      wren <= s1_vld && s1_odd;
      if (s1_vld && !s1_odd) v <= mx;
      if (s1_vld && s1_odd) begin
        d <= pl;
        wraddr <= s1_wa;
        bram_num <= s1_bk;
      end
    end
endmodule
